// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg
//   Shared types and constants for the APB4 register access controller and
//   its address decoder: FSM state encoding, register byte offsets and the
//   APB response codes driven on PSLVERR.
package apb_reg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Byte offsets into the configuration bank (word index = offset >> 2).
  localparam logic [11:0] SLV_CTRL_OFS   = 12'h000;
  localparam logic [11:0] SLV_STATUS_OFS = 12'h004;
  localparam logic [11:0] SLV_CONFIG_OFS = 12'h010;  // index 4

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

endpackage

// File: rtl/apb_reg_access_ctrl_decode.sv
// apb_reg_addr_decode
//   Combinational decode of an APB setup phase into a register word index
//   and an error flag. The flag covers unaligned addresses, indices past the
//   end of the bank and writes that do not enable all four byte lanes
//   (the bank only supports full-word writes).
// Ports
//   i_paddr  : APB byte address
//   i_pstrb  : APB write byte strobes
//   i_pwrite : 1 = write transfer
//   o_idx    : word index paddr[ADDR_W-1:2]
//   o_err    : transfer must complete with an error response
module apb_reg_addr_decode import apb_reg_pkg::*; #(
  parameter int ADDR_W   = 12,
  parameter int NUM_REGS = 8
) (
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic [3:0]        i_pstrb,
  input  logic              i_pwrite,
  output logic [ADDR_W-3:0] o_idx,
  output logic              o_err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  assign o_idx = i_paddr[ADDR_W-1:2];
  assign o_err = (i_paddr[1:0] != 2'b00) ||
                 (o_idx > LAST_IDX) ||
                 (i_pwrite && (i_pstrb != 4'hF));

endmodule

// File: rtl/apb_reg_access_ctrl.sv
// apb_reg_access_ctrl
//   APB4 slave front end for a bank of NUM_REGS 32-bit registers. A setup
//   phase latches the transfer, WAIT_STATES access cycles are inserted, and
//   the completion cycle either pulses a one-hot write strobe, returns read
//   data, or reports a decode error.
// Ports
//   i_clk, i_rstn       : clock, synchronous active-low reset
//   i_psel .. i_pstrb   : APB4 request
//   o_prdata, o_pready,
//   o_pslverr           : APB4 response (data/err forced 0 while not ready)
//   o_reg_write         : one-hot write strobe, completion cycle only
//   o_reg_wdata         : data for o_reg_write
//   i_reg_rdata         : concatenated bank read values, reg i at [32i+:32]
//   i_use_merr_resp     : 1 = decode errors reported on PSLVERR
//   o_err_count         : saturating count of erroneous transfers
module apb_reg_access_ctrl import apb_reg_pkg::*; #(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_W-1:0]     i_paddr,
  input  logic [31:0]           i_pwdata,
  input  logic [3:0]            i_pstrb,
  output logic [31:0]           o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr,
  output logic [NUM_REGS-1:0]   o_reg_write,
  output logic [31:0]           o_reg_wdata,
  input  logic [NUM_REGS*32-1:0] i_reg_rdata,
  input  logic                  i_use_merr_resp,
  output logic [7:0]            o_err_count
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] WS_LD = 4'(WAIT_STATES);

  state_t           r_state;
  logic [3:0]       r_wcnt;
  logic             r_write;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [7:0]       r_err_cnt;

  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_pready;
  logic             w_done;
  logic             w_wr_fire;
  logic [31:0]      w_rd_word;

  apb_reg_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .i_paddr  (i_paddr),
    .i_pstrb  (i_pstrb),
    .i_pwrite (i_pwrite),
    .o_idx    (w_idx),
    .o_err    (w_err)
  );

  // Ready comes only from flops so PREADY never depends on APB inputs.
  assign w_pready  = (r_state == ACCESS) && (r_wcnt == 4'd0);
  assign w_done    = w_pready && i_psel && i_penable;
  assign w_wr_fire = w_done && r_write && !r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= IDLE;
      r_wcnt    <= 4'd0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_err_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          // penable without a preceding setup phase is ignored here
          if (i_psel && !i_penable) begin
            r_state <= ACCESS;
            r_write <= i_pwrite;
            r_wdata <= i_pwdata;
            r_idx   <= w_idx;
            r_err   <= w_err;
            r_wcnt  <= WS_LD;
          end
        end
        ACCESS: begin
          if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
          if (!i_psel) begin
            // master abandoned the transfer: no strobe, no error count
            r_state <= IDLE;
          end else if (w_done) begin
            r_state <= IDLE;
            if (r_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (r_idx == IDX_W'(i)) w_rd_word = i_reg_rdata[i*32 +: 32];
  end

  always_comb begin
    o_reg_write = '0;
    for (int i = 0; i < NUM_REGS; i++)
      o_reg_write[i] = w_wr_fire && (r_idx == IDX_W'(i));
  end

  assign o_pready    = w_pready;
  assign o_prdata    = (w_pready && !r_err && !r_write) ? w_rd_word : 32'd0;
  assign o_pslverr   = (w_pready && r_err && i_use_merr_resp) ? APB_ERR : APB_OKAY;
  assign o_reg_wdata = r_wdata;
  assign o_err_count = r_err_cnt;

endmodule

// File: doc/apb_reg_access_ctrl.md
# apb_reg_access_ctrl

APB4 slave access controller that sequences reads and writes into the peripheral's bank of 32-bit configuration registers, such as the slave config register at offset 0x010. It sits between the APB4 port of the AXI4-Lite-to-APB4 bridge and the register bank. It decodes the address, inserts programmable wait states, and pulses one-hot write strobes. It returns read data and produces PSLVERR under control of the `use_merr_resp` configuration bit.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers at word offsets 0x000..(NUM_REGS-1)*4.
- `ADDR_W`, 12: PADDR width.
- `WAIT_STATES`, 1: wait cycles inserted in the access phase (0..15).
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `psel` in 1: APB4 select.
- `penable` in 1: APB4 enable.
- `pwrite` in 1: 1 = write.
- `paddr` in ADDR_W: byte address.
- `pwdata` in 32: write data.
- `pstrb` in 4: write byte strobes.
- `prdata` out 32: read data, valid when pready=1.
- `pready` out 1: transfer completes this cycle.
- `pslverr` out 1: error response, valid only when pready=1.
- `reg_write` out NUM_REGS: one-hot write strobe, single-cycle pulse.
- `reg_wdata` out 32: data for reg_write.
- `reg_rdata` in NUM_REGS*32: concatenated register read values; register i occupies bits [32i+31:32i].
- `use_merr_resp` in 1: 1 = report decode errors on pslverr; 0 = silently OKAY.
- `err_count` out 8: saturating count of erroneous transfers.

## Operation
- FSM states are IDLE and ACCESS.
- **IDLE → ACCESS:** taken on `psel && !penable` (setup phase).
  - At that edge, latch `pwrite`, `pwdata` and the register index `paddr[ADDR_W-1:2]`.
  - Also latch `err = (paddr[1:0]!=0) || (index>=NUM_REGS) || (pwrite && pstrb!=4'hF)`.
  - Load `wcnt = WAIT_STATES`.
- **In ACCESS:** `wcnt` decrements each cycle while nonzero.
  - `pready = (state==ACCESS) && (wcnt==0)`, decoded from flops only, with no combinational path from APB inputs.
- **Completion:** occurs in the cycle where `pready=1` and `penable=1`.
  - Write, no error: `reg_write[index]=1` for exactly that cycle, with `reg_wdata` = latched `pwdata`.
  - Read, no error: `prdata = reg_rdata[index]`.
  - Error: no `reg_write`, `prdata=0`, `pslverr=use_merr_resp` (sampled in the completion cycle), and `err_count` increments, saturating at 0xFF.
  - The next state is IDLE. A new setup phase may follow in the very next cycle (back-to-back transfers).
- **Abort:** if `psel` drops while in ACCESS, return to IDLE with no strobe, no error count, and `pready` low.
- `prdata` and `pslverr` are 0 whenever `pready=0`.
- `penable` high while in IDLE (protocol violation) is ignored.

## Timing
- **Reset values:** state=IDLE, `wcnt=0`, `pready=0`, `pslverr=0`, `prdata=0`, `reg_write=0`, `reg_wdata=0`, `err_count=0`.
- **Latency:** setup cycle plus `WAIT_STATES+1` access cycles. With WAIT_STATES=0 this is 2 cycles per transfer, which is APB zero-wait.
- **Write visibility:** the register updates on the edge ending the completion cycle, so a read beginning in the next setup phase returns the new value.
- **Reset mid-transfer:** `rstn` low in any ACCESS cycle forces IDLE at that edge. No `reg_write` pulse occurs and `err_count` is cleared.
- **Simultaneous events:** when an error and the `err_count` saturation point coincide, the count holds at 0xFF.

## Structure
- Package `apb_reg_pkg` holds:
  - the `state_t` enum (IDLE, ACCESS);
  - register offset constants, including `SLV_CONFIG_OFS = 12'h010`, which is index 4;
  - the `APB_OKAY` and `APB_ERR` constants.
- One sub-module, `apb_reg_addr_decode`: combinational index and error decode from paddr/pstrb/pwrite. It is reused by future register-bank controllers.
- The read mux and FSM live in the top module.

## Test plan
- **Write then read-back:** WAIT_STATES=1; write 0x0000_0001 to 0x010, then read 0x010.
  - Write: `reg_write=8'b0001_0000` for one cycle, with pready in the 3rd cycle.
  - Read: prdata=0x0000_0001 and pslverr=0.
- **Unaligned or out-of-range, merr on:** `use_merr_resp=1`; write to 0x012, then read 0x020.
  - Both: pslverr=1, no `reg_write`, prdata=0.
  - `err_count` reaches 2.
- **Partial strobe, merr off:** `use_merr_resp=0`; write with pstrb=4'h3.
  - pslverr=0, no `reg_write`, `err_count` increments.
- **Back-to-back, zero-wait:** WAIT_STATES=0; four consecutive writes to indices 0..3 with no idle cycles.
  - One strobe per 2-cycle transfer, in order.
- **Reset mid-transfer:** assert rstn=0 during the wait cycle of a write.
  - No `reg_write`; all outputs return to reset values on the next cycle.
- **Abort and saturation:** drop psel mid-ACCESS, then drive 256 erroneous transfers.
  - Abort: return to IDLE with no strobe and no error count.
  - Saturation: `err_count` holds at 0xFF.
